// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the traffic phase controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_ALL_RED   = 3'd0,
    ST_GREEN     = 3'd1,
    ST_YELLOW    = 3'd2,
    ST_EM_YELLOW = 3'd3,
    ST_EM_ALLRED = 3'd4,
    ST_EM_GREEN  = 3'd5
  } state_t;

  // Vehicle nibble is {green, left, yellow, red}; pedestrian pair is {walk, stop}.
  localparam logic [3:0] LAMP_RED = 4'b0001;
  localparam logic [3:0] LAMP_YEL = 4'b0010;
  localparam logic [3:0] LAMP_GO  = 4'b1100;
  localparam logic [1:0] PED_STOP = 2'b01;
  localparam logic [1:0] PED_WALK = 2'b10;

endpackage

// File: rtl/traffic_phase_controller_sec_timer.sv
// Seconds timer: prescaler producing a 1 s tick plus an 8-bit seconds down-counter.
// Latency: load takes effect on the next clock; tick/half_tick/expire are combinational.
// Backpressure: none; load always wins over counting.
// Ports: clock, reset (async active-low), load/load_val (restart with a new
//        seconds value), tick (last prescaler cycle), half_tick (middle of the
//        second), expire (tick while count==1), count (seconds remaining).
module sec_timer #(
  parameter int         TICK_DIV = 1000,
  parameter logic [7:0] INIT_VAL = 8'd2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       tick,
  output logic       half_tick,
  output logic       expire,
  output logic [7:0] count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] HALF = PW'((TICK_DIV >= 2) ? (TICK_DIV / 2 - 1) : 0);

  logic [PW-1:0] presc;

  assign tick      = (presc == LAST);
  assign half_tick = (presc == HALF);
  assign expire    = tick && (count == 8'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      count <= INIT_VAL;
    end else if (load) begin
      presc <= '0;
      count <= load_val;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      // A zero count is the untimed hold; it must not wrap.
      if (tick && (count != 8'd0)) begin
        count <= count - 8'd1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// N-direction round-robin traffic controller with latched pedestrian requests and emergency pre-emption.
// Latency: emergency input acts 3 clocks after it rises (2-flop sync + decision); timed states last T*TICK_DIV clocks.
// Backpressure: none; inputs are sampled every clock, outputs decode the current state.
// Ports: clock, reset (async active-low), emergent_control (async level),
//        emergency_dir, ped_req[N_DIR], vehicle_signal[4*N_DIR],
//        pedestrian_signal[2*N_DIR], cur_phase, time_left (seconds).
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int N_DIR       = 4,
  parameter int TICK_DIV    = 1000,
  parameter int GREEN_T     = 20,
  parameter int YELLOW_T    = 3,
  parameter int ALLRED_T    = 2,
  parameter int PED_CLEAR_T = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     emergent_control,
  input  logic [$clog2(N_DIR)-1:0] emergency_dir,
  input  logic [N_DIR-1:0]         ped_req,
  output logic [4*N_DIR-1:0]       vehicle_signal,
  output logic [2*N_DIR-1:0]       pedestrian_signal,
  output logic [$clog2(N_DIR)-1:0] cur_phase,
  output logic [7:0]               time_left
);

  localparam int PW = $clog2(N_DIR);
  localparam logic [7:0]    GREEN_V  = 8'(GREEN_T);
  localparam logic [7:0]    YELLOW_V = 8'(YELLOW_T);
  localparam logic [7:0]    ALLRED_V = 8'(ALLRED_T);
  localparam logic [7:0]    PED_V    = 8'(PED_CLEAR_T);
  localparam logic [PW-1:0] LAST_PH  = PW'(N_DIR - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [PW-1:0] em_dir, em_dir_nxt;
  logic          em_meta, em_s;
  logic [N_DIR-1:0] ped_latch, ped_clr;
  logic          walk_active, flash, green_entry;
  logic          load, tick, half_tick, expire;
  logic [7:0]    load_val, count;

  sec_timer #(.TICK_DIV(TICK_DIV), .INIT_VAL(ALLRED_V)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_val  (load_val),
    .tick      (tick),
    .half_tick (half_tick),
    .expire    (expire),
    .count     (count)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_ALL_RED;
      phase  <= '0;
      em_dir <= '0;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      em_dir <= em_dir_nxt;
    end
  end

  // Next state; every state change reloads the seconds timer.
  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    em_dir_nxt = em_dir;
    load       = 1'b0;
    load_val   = 8'd0;
    unique case (state)
      ST_ALL_RED: if (expire) begin
        load = 1'b1;
        if (em_s) begin
          state_nxt  = ST_EM_GREEN;
          em_dir_nxt = emergency_dir;
          phase_nxt  = emergency_dir;
        end else begin
          state_nxt = ST_GREEN;
          load_val  = GREEN_V;
        end
      end
      ST_GREEN: begin
        // Emergency is checked first so it beats a coincident expiry.
        if (em_s) begin
          load       = 1'b1;
          em_dir_nxt = emergency_dir;
          if (emergency_dir == phase) begin
            state_nxt = ST_EM_GREEN;
          end else begin
            state_nxt = ST_EM_YELLOW;
            load_val  = YELLOW_V;
          end
        end else if (expire) begin
          load      = 1'b1;
          state_nxt = ST_YELLOW;
          load_val  = YELLOW_V;
        end
      end
      ST_YELLOW: if (expire) begin
        load      = 1'b1;
        state_nxt = ST_ALL_RED;
        load_val  = ALLRED_V;
        // cur_phase already names the upcoming direction during all-red.
        phase_nxt = (phase == LAST_PH) ? '0 : phase + 1'b1;
      end
      ST_EM_YELLOW: if (expire) begin
        load      = 1'b1;
        state_nxt = ST_EM_ALLRED;
        load_val  = ALLRED_V;
      end
      ST_EM_ALLRED: if (expire) begin
        load      = 1'b1;
        state_nxt = ST_EM_GREEN;
        phase_nxt = em_dir;
      end
      ST_EM_GREEN: if (!em_s) begin
        load      = 1'b1;
        state_nxt = ST_YELLOW;
        load_val  = YELLOW_V;
      end
      default: begin
        load      = 1'b1;
        state_nxt = ST_ALL_RED;
        load_val  = ALLRED_V;
      end
    endcase
  end

  assign green_entry = (state == ST_ALL_RED) && (state_nxt == ST_GREEN);
  assign ped_clr     = green_entry ? (N_DIR'(1) << phase_nxt) : '0;

  // Emergency sync, pedestrian latches, walk grant and walk flash phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      em_meta     <= 1'b0;
      em_s        <= 1'b0;
      ped_latch   <= '0;
      walk_active <= 1'b0;
      flash       <= 1'b1;
    end else begin
      em_meta   <= emergent_control;
      em_s      <= em_meta;
      // A press in the entry cycle itself is kept for the next visit.
      ped_latch <= (ped_latch & ~ped_clr) | ped_req;
      if (green_entry) begin
        walk_active <= ped_latch[phase_nxt];
      end else if (state_nxt != ST_GREEN) begin
        walk_active <= 1'b0;
      end
      // Flash is high for the first half of every second of the state.
      if (load) begin
        flash <= 1'b1;
      end else if (tick || half_tick) begin
        flash <= ~flash;
      end
    end
  end

  // Outputs
  always_comb begin
    for (int d = 0; d < N_DIR; d++) begin
      vehicle_signal[4*d +: 4]    = LAMP_RED;
      pedestrian_signal[2*d +: 2] = PED_STOP;
    end
    unique case (state)
      ST_GREEN, ST_EM_GREEN:   vehicle_signal[4*int'(phase) +: 4] = LAMP_GO;
      ST_YELLOW, ST_EM_YELLOW: vehicle_signal[4*int'(phase) +: 4] = LAMP_YEL;
      default: ;
    endcase
    if ((state == ST_GREEN) && walk_active) begin
      pedestrian_signal[2*int'(phase) +: 2] = (count > PED_V) ? PED_WALK : {flash, 1'b0};
    end
  end

  assign cur_phase = phase;
  assign time_left = count;

endmodule
